uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter, consuming its `Txd` line. It oversamples the asynchronous serial input with the system clock and recovers 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. Each good byte goes into a one-entry holding buffer with a data-buffer-full flag and a read handshake. Framing and overrun errors are flagged.

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-edge alignment, mid-bit sampling,
// one-entry holding buffer with read handshake, framing and overrun flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       dbf,
  output logic       fe,
  output logic       oe,
  output logic       busy
);

  localparam int unsigned N  = CLKS_PER_BIT;
  localparam int unsigned H  = N / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync;
  logic            rxs;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bitn, bitn_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      data_nxt;
  logic            dbf_nxt, fe_nxt, oe_nxt, busy_nxt;

  assign rxs = sync[1];

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], Rxd};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
      data  <= '0;
      dbf   <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bitn_nxt;
      shift <= shift_nxt;
      data  <= data_nxt;
      dbf   <= dbf_nxt;
      fe    <= fe_nxt;
      oe    <= oe_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next-state and buffer/flag updates; frame completion overrides a same-cycle read
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bitn_nxt  = bitn;
    shift_nxt = shift;
    data_nxt  = data;
    dbf_nxt   = dbf;
    fe_nxt    = fe;
    oe_nxt    = oe;

    if (rd && dbf) begin
      dbf_nxt = 1'b0;
      oe_nxt  = 1'b0;
      fe_nxt  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rxs) begin
            state_nxt = DATA;
            bitn_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = CW'(cnt + 1'b1);
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          shift_nxt = {rxs, shift[7:1]};
          bitn_nxt  = bitn + 3'd1;
          if (bitn == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = CW'(cnt + 1'b1);
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rxs) begin
            data_nxt  = shift;
            dbf_nxt   = 1'b1;
            fe_nxt    = 1'b0;
            if (dbf && !rd) begin
              oe_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = CW'(cnt + 1'b1);
        end
      end
      BREAK: begin
        if (rxs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes predicted buffer/flag state and
// completion cycle; a monitor pops on every frame end or buffer release.
module tb_uart_rx;

  localparam int N = 12;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rxd;
  logic       rd;
  logic [7:0] data;
  logic       dbf, fe, oe, busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .Rxd  (Rxd),
    .rd   (rd),
    .data (data),
    .dbf  (dbf),
    .fe   (fe),
    .oe   (oe),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    bit          dbf;
    bit          fe;
    bit          oe;
    int unsigned cyc;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int          id_n = 0;

  // Reference model of the consumer-visible state
  logic [7:0]  m_data;
  bit          m_dbf, m_fe, m_oe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (event %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic push(input int unsigned at);
    exp_t e;
    e.data = m_data;
    e.dbf  = m_dbf;
    e.fe   = m_fe;
    e.oe   = m_oe;
    e.cyc  = at;
    e.id   = id_n;
    id_n++;
    sbq.push_back(e);
  endtask

  // Called at a falling edge; the start bit is first seen on edge s = cyc+1.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int hold_low);
    int unsigned s;
    s = cyc + 1;
    if (stop) begin
      if (m_dbf) m_oe = 1'b1;
      m_data = b;
      m_dbf  = 1'b1;
      m_fe   = 1'b0;
      push(s + 2 + H + 9 * N);
    end else begin
      m_fe = 1'b1;
      push(s + 10 * N + hold_low + 2);
    end
    Rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rxd = b[i];
      repeat (N) @(negedge clk);
    end
    Rxd = stop;
    repeat (N) @(negedge clk);
    if (!stop) begin
      repeat (hold_low) @(negedge clk);
      Rxd = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic glitch(input int g);
    int unsigned s;
    s = cyc + 1;
    push(s + 2 + H);
    Rxd = 1'b0;
    repeat (g) @(negedge clk);
    Rxd = 1'b1;
    repeat (H + 4) @(negedge clk);
  endtask

  task automatic do_rd();
    if (m_dbf) begin
      m_dbf = 1'b0;
      m_oe  = 1'b0;
      m_fe  = 1'b0;
      push(cyc + 1);
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic reset_mid(input logic [7:0] b);
    Rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      Rxd = b[i];
      repeat (N) @(negedge clk);
    end
    Rxd = b[4];
    repeat (H) @(negedge clk);
    m_data = 8'h00;
    m_dbf  = 1'b0;
    m_fe   = 1'b0;
    m_oe   = 1'b0;
    push(cyc + 1);
    rst = 1'b0;
    Rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * N) @(negedge clk);
  endtask

  // Monitor: a frame end (busy falls) or buffer release (dbf falls) is one event
  initial begin
    bit   pb;
    bit   pd;
    exp_t e;
    pb = 1'b0;
    pd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ((pb && busy === 1'b0) || (pd && dbf === 1'b0)) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got event at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("data",  e.id, 32'(data), 32'(e.data));
          chk("dbf",   e.id, 32'(dbf),  32'(e.dbf));
          chk("fe",    e.id, 32'(fe),   32'(e.fe));
          chk("oe",    e.id, 32'(oe),   32'(e.oe));
          chk("busy",  e.id, 32'(busy), 32'd0);
          chk("cycle", e.id, cyc,       e.cyc);
        end
      end
      pb = (busy === 1'b1);
      pd = (dbf === 1'b1);
    end
  end

  initial begin
    int unsigned op;
    rst    = 1'b0;
    Rxd    = 1'b1;
    rd     = 1'b0;
    m_data = 8'h00;
    m_dbf  = 1'b0;
    m_fe   = 1'b0;
    m_oe   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_data", -1, 32'(data), 32'h00);
    chk("reset_dbf",  -1, 32'(dbf),  32'd0);
    chk("reset_fe",   -1, 32'(fe),   32'd0);
    chk("reset_oe",   -1, 32'(oe),   32'd0);
    chk("reset_busy", -1, 32'(busy), 32'd0);

    send_frame(8'h55, 1'b1, 0);
    do_rd();
    send_frame(8'hA3, 1'b1, 0);
    repeat (4) @(negedge clk);
    do_rd();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    do_rd();
    send_frame(8'h7E, 1'b1, 0);
    glitch(3);
    send_frame(8'h7E, 1'b1, 0);
    do_rd();
    send_frame(8'hF0, 1'b0, 30);
    send_frame(8'h0F, 1'b1, 0);
    reset_mid(8'hC3);
    send_frame(8'hC3, 1'b1, 0);
    do_rd();
    do_rd();

    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 9);
      if (op < 7) begin
        send_frame(8'($urandom), 1'b1, 0);
      end else if (op < 9) begin
        send_frame(8'($urandom), 1'b0, int'($urandom_range(0, 20)));
      end else begin
        glitch(int'($urandom_range(1, H)));
      end
      if ($urandom_range(0, 9) < 4) do_rd();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", sbq.size());
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
